parking_allocator: RTL and testbench

- Assigns free parking spots to cars arriving at several entry gates, and frees spots when cars leave.
- Arbitrates between the gates and keeps an occupancy bitmap.
- Drives the spot code and the LED-enable pair consumed by the parking LED indicator: `pasignado` is a 4-bit code where 1..6 is a spot and 0 is none; `led` is the enable.
- Sits between the gate sensors/exit readers and the LED indicator stage.

---
 rtl/parking_pkg.sv | 24 ++
 rtl/parking_allocator_rr_arbiter.sv | 65 ++++++
 rtl/parking_allocator.sv | 137 +++++++++++++
 tb/tb_parking_allocator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking allocator.
package parking_pkg;

    localparam int SPOT_W    = 4;
    localparam int MAX_SPOTS = 15;
    localparam logic [SPOT_W-1:0] SPOT_NONE = 4'd0;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Index (0-based) of the lowest clear bit; returns MAX_SPOTS when none is free.
    // Callers pad unused high bits with ones so they never look free.
    function automatic logic [SPOT_W-1:0] lowest_free(input logic [MAX_SPOTS-1:0] occ);
        logic [SPOT_W-1:0] idx;
        idx = SPOT_W'(MAX_SPOTS);
        for (int i = MAX_SPOTS - 1; i >= 0; i--) begin
            if (!occ[i]) idx = SPOT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_allocator_rr_arbiter.sv
// Gate arbiter for the parking allocator.
// Default: round-robin from a pointer that moves past each winner.
// With UNPARK_FIXED_PRIO_EN defined: lowest-index requesting gate always wins.
module rr_arbiter #(
    parameter int NUM_GATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_GATES-1:0] req,
    input  logic                 advance,
    output logic [NUM_GATES-1:0] grant,
    output logic                 any_req
);

    localparam int PTR_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

    logic found;

    assign any_req = |req;

`ifdef UNPARK_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = clk ^ rst_n ^ advance;

    // Fixed priority: first requester from gate 0 upward.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_GATES; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win;

    // Search from the pointer, wrapping, and move the pointer past the winner on advance.
    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = '0;
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_GATES; i++) begin
            if (!found && req[PTR_W'((int'(ptr_q) + i) % NUM_GATES)]) begin
                win   = PTR_W'((int'(ptr_q) + i) % NUM_GATES);
                found = 1'b1;
            end
        end
        if (found) grant[win] = 1'b1;
        if (advance && found) begin
            ptr_d = (int'(win) == NUM_GATES - 1) ? '0 : PTR_W'(int'(win) + 1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

endmodule

// File: rtl/parking_allocator.sv
// Parking spot allocator: arbitrates entry gates, hands out the lowest free
// spot, shows it on pasignado/led for SHOW_CYCLES cycles, and tracks
// occupancy with releases from the exit readers.
// Optional macro UNPARK_FIXED_PRIO_EN selects fixed-priority gate arbitration.
//
// state | meaning
// IDLE  | waiting for a request while a spot is free
// SHOW  | displaying the just-assigned spot; requests wait
module parking_allocator
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS   = 6,
    parameter int NUM_GATES   = 2,
    parameter int SHOW_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_GATES-1:0] req,
    output logic [NUM_GATES-1:0] gnt,
    input  logic                 rel_valid,
    input  logic [3:0]           rel_spot,
    output logic [3:0]           pasignado,
    output logic                 led,
    output logic                 full,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [3:0]           free_count
);

    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_GATES-1:0] gnt_q, gnt_d;
    logic [SPOT_W-1:0]    pasignado_q, pasignado_d;
    logic                 led_q, led_d;
    logic [NUM_SPOTS-1:0] occ_q, occ_d;
    logic [SPOT_W-1:0]    free_count_q, free_count_d;
    logic                 full_q, full_d;

    logic [NUM_GATES-1:0] grant;
    logic                 any_req;
    logic                 alloc;
    logic [MAX_SPOTS-1:0] occ_pad;
    logic [SPOT_W-1:0]    spot_idx;
    logic [NUM_SPOTS-1:0] alloc_mask, rel_mask;

    rr_arbiter #(.NUM_GATES(NUM_GATES)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (alloc),
        .grant   (grant),
        .any_req (any_req)
    );

    // Next state, display outputs and occupancy update; allocation sees pre-release occupancy.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        pasignado_d = pasignado_q;
        led_d       = led_q;
        alloc       = 1'b0;

        occ_pad                = '1;
        occ_pad[NUM_SPOTS-1:0] = occ_q;
        spot_idx               = lowest_free(occ_pad);

        case (state_q)
            IDLE: begin
                pasignado_d = SPOT_NONE;
                led_d       = 1'b0;
                if (any_req && !full_q) begin
                    alloc       = 1'b1;
                    state_d     = SHOW;
                    gnt_d       = grant;
                    pasignado_d = spot_idx + 4'd1;
                    led_d       = 1'b1;
                    cnt_d       = CNT_W'(SHOW_CYCLES - 1);
                end
            end
            SHOW: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    pasignado_d = SPOT_NONE;
                    led_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_SPOTS; i++) begin
            alloc_mask[i] = alloc && (spot_idx == SPOT_W'(i));
            rel_mask[i]   = rel_valid && (rel_spot == SPOT_W'(i + 1));
        end
        occ_d = (occ_q & ~rel_mask) | alloc_mask;

        free_count_d = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            free_count_d = free_count_d + SPOT_W'(!occ_d[i]);
        end
        full_d = &occ_d;
    end

    // State, display and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= '0;
            pasignado_q  <= SPOT_NONE;
            led_q        <= 1'b0;
            occ_q        <= '0;
            free_count_q <= SPOT_W'(NUM_SPOTS);
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            pasignado_q  <= pasignado_d;
            led_q        <= led_d;
            occ_q        <= occ_d;
            free_count_q <= free_count_d;
            full_q       <= full_d;
        end
    end

    assign gnt        = gnt_q;
    assign pasignado  = pasignado_q;
    assign led        = led_q;
    assign occupancy  = occ_q;
    assign free_count = free_count_q;
    assign full       = full_q;

endmodule

// File: tb/tb_parking_allocator.sv
// Bench for parking_allocator: directed stimulus pushes expected allocations
// into a queue; a monitor pops and compares whenever a grant appears.
module tb_parking_allocator;

    localparam int SHOW_CYCLES = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       rel_valid;
    logic [3:0] rel_spot;
    logic [3:0] pasignado;
    logic       led;
    logic       full;
    logic [5:0] occupancy;
    logic [3:0] free_count;

    typedef struct {
        logic [1:0] gnt;
        logic [3:0] spot;
        logic [5:0] occ;
        logic [3:0] free;
        logic       full;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   led_run   = 0;

    parking_allocator #(
        .NUM_SPOTS   (6),
        .NUM_GATES   (2),
        .SHOW_CYCLES (SHOW_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .rel_valid  (rel_valid),
        .rel_spot   (rel_spot),
        .pasignado  (pasignado),
        .led        (led),
        .full       (full),
        .occupancy  (occupancy),
        .free_count (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [1:0] g, input logic [3:0] s,
                                input logic [5:0] o, input logic [3:0] f, input logic fl);
        exp_t e;
        e.gnt = g; e.spot = s; e.occ = o; e.free = f; e.full = fl;
        return e;
    endfunction

    // Monitor: compare each grant against the scoreboard and time the led pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                led_run = 0;
            end else begin
                if (gnt != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_grant: got gnt=%b expected none", gnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt", int'(gnt), int'(e.gnt));
                        chk("pasignado", int'(pasignado), int'(e.spot));
                        chk("led_on_grant", int'(led), 1);
                        chk("occupancy", int'(occupancy), int'(e.occ));
                        chk("free_count", int'(free_count), int'(e.free));
                        chk("full", int'(full), int'(e.full));
                    end
                end
                if (led) begin
                    led_run++;
                end else if (led_run != 0) begin
                    chk("led_width", led_run, SHOW_CYCLES);
                    chk("pasignado_after_show", int'(pasignado), 0);
                    led_run = 0;
                end
            end
        end
    end

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00) return;
        end
        total_cnt++;
        $display("FAIL grant_timeout: got no grant expected one within 20 cycles");
    endtask

    task automatic alloc(input logic [1:0] r, input exp_t e);
        exp_q.push_back(e);
        req = r;
        wait_gnt();
        req = 2'b00;
        repeat (SHOW_CYCLES) @(posedge clk);
        #1;
    endtask

    task automatic release_spot(input logic [3:0] s);
        rel_valid = 1'b1;
        rel_spot  = s;
        @(posedge clk); #1;
        rel_valid = 1'b0;
        rel_spot  = 4'd0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req       = 2'b00;
        rel_valid = 1'b0;
        rel_spot  = 4'd0;
        #12;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_pasignado", int'(pasignado), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_free_count", int'(free_count), 6);
        chk("rst_full", int'(full), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single allocation from gate 0.
        alloc(2'b01, mk(2'b01, 4'd1, 6'b000001, 4'd5, 1'b0));
        chk("t1_pasignado_idle", int'(pasignado), 0);
        chk("t1_led_idle", int'(led), 0);

        // Both gates requesting: round-robin from gate 0 until the lot is full.
        reset_dut();
        exp_q.push_back(mk(2'b01, 4'd1, 6'b000001, 4'd5, 1'b0));
        exp_q.push_back(mk(2'b10, 4'd2, 6'b000011, 4'd4, 1'b0));
        exp_q.push_back(mk(2'b01, 4'd3, 6'b000111, 4'd3, 1'b0));
        exp_q.push_back(mk(2'b10, 4'd4, 6'b001111, 4'd2, 1'b0));
        exp_q.push_back(mk(2'b01, 4'd5, 6'b011111, 4'd1, 1'b0));
        exp_q.push_back(mk(2'b10, 4'd6, 6'b111111, 4'd0, 1'b1));
        req = 2'b11;
        n = 0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00) n++;
        end
        chk("t2_grant_count", n, 6);
        repeat (20) @(posedge clk);
        #1;
        chk("t2_full", int'(full), 1);
        chk("t2_led_when_full", int'(led), 0);
        chk("t2_free_count", int'(free_count), 0);

        // Full lot, gate 0 waiting; release spot 3 and expect it reassigned.
        req = 2'b01;
        exp_q.push_back(mk(2'b01, 4'd3, 6'b111111, 4'd0, 1'b1));
        release_spot(4'd3);
        chk("t3_full_after_rel", int'(full), 0);
        chk("t3_free_after_rel", int'(free_count), 1);
        chk("t3_occ_after_rel", int'(occupancy), 6'b111011);
        wait_gnt();
        req = 2'b00;
        repeat (SHOW_CYCLES) @(posedge clk);
        #1;

        // Release a valid spot, then ignored codes and a repeat release.
        release_spot(4'd5);
        chk("t4_occ_rel5", int'(occupancy), 6'b101111);
        chk("t4_free_rel5", int'(free_count), 1);
        release_spot(4'd0);
        chk("t4_occ_rel0", int'(occupancy), 6'b101111);
        chk("t4_free_rel0", int'(free_count), 1);
        release_spot(4'd9);
        chk("t4_occ_rel9", int'(occupancy), 6'b101111);
        chk("t4_free_rel9", int'(free_count), 1);
        release_spot(4'd5);
        chk("t4_occ_rel5_again", int'(occupancy), 6'b101111);
        chk("t4_free_rel5_again", int'(free_count), 1);

        // Release of spot 2 on the same edge that allocates spot 1.
        reset_dut();
        alloc(2'b01, mk(2'b01, 4'd1, 6'b000001, 4'd5, 1'b0));
        alloc(2'b10, mk(2'b10, 4'd2, 6'b000011, 4'd4, 1'b0));
        release_spot(4'd1);
        chk("t5_occ_pre", int'(occupancy), 6'b000010);
        exp_q.push_back(mk(2'b01, 4'd1, 6'b000001, 4'd5, 1'b0));
        req       = 2'b01;
        rel_valid = 1'b1;
        rel_spot  = 4'd2;
        @(posedge clk); #1;
        rel_valid = 1'b0;
        rel_spot  = 4'd0;
        req       = 2'b00;
        chk("t5_occ_post", int'(occupancy), 6'b000001);
        repeat (SHOW_CYCLES) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of showing spot 4.
        alloc(2'b10, mk(2'b10, 4'd2, 6'b000011, 4'd4, 1'b0));
        alloc(2'b01, mk(2'b01, 4'd3, 6'b000111, 4'd3, 1'b0));
        exp_q.push_back(mk(2'b01, 4'd4, 6'b001111, 4'd2, 1'b0));
        req = 2'b01;
        wait_gnt();
        req = 2'b00;
        @(posedge clk); #3;
        chk("t6_led_mid_show", int'(led), 1);
        chk("t6_pasignado_mid_show", int'(pasignado), 4);
        rst_n = 1'b0;
        #1;
        chk("t6_async_led", int'(led), 0);
        chk("t6_async_pasignado", int'(pasignado), 0);
        chk("t6_async_gnt", int'(gnt), 0);
        chk("t6_async_occupancy", int'(occupancy), 0);
        chk("t6_async_free_count", int'(free_count), 6);
        @(posedge clk); #1;
        rst_n = 1'b1;
        alloc(2'b10, mk(2'b10, 4'd1, 6'b000001, 4'd5, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
